// File: rtl/key_pkg.sv
// Board-level constants shared by the key conditioning blocks (50 MHz system clock).
// The width helper keeps counters at least one bit wide for degenerate parameter choices.
package key_pkg;

  localparam int KEY_CNT_MAX    = 999_999;  // 20 ms debounce window minus one clock
  localparam int KEY_TICK_DIV   = 50_000;   // 1 ms hold-timer tick
  localparam int KEY_LONG_TICKS = 1000;     // 1 s long-press threshold
  localparam int KEY_ACTIVE_LOW = 1;        // board keys pull the pin low when pressed

  function automatic int key_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, symmetric debounce window, hold timer and
// registered press / release / long-press pulses.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int CNT_MAX    = KEY_CNT_MAX,
  parameter int LONG_TICKS = KEY_LONG_TICKS,
  parameter int ACTIVE_LOW = KEY_ACTIVE_LOW
) (
  input  logic clk,
  input  logic sys_rst,
  input  logic tick_i,
  input  logic key_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int CNT_W  = key_width(CNT_MAX + 1);
  localparam int LONG_W = key_width(LONG_TICKS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CNT_MAX);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_TICKS);

  logic              pressed_raw;
  logic              sync1_q, sync2_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              level_q, level_d;
  logic [LONG_W-1:0] hold_q, hold_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  // Normalise so that 1 always means "pressed" from here on.
  assign pressed_raw = (ACTIVE_LOW != 0) ? ~key_raw_i : key_raw_i;

  // Synchroniser resets to the released level so reset never yields a press.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pressed_raw;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q < CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      level_d   = sync2_q;
      cnt_d     = '0;
      press_d   = sync2_q;
      release_d = ~sync2_q;
    end
  end

  // Hold timer only runs while the debounced level was already high, so a
  // long pulse can never land on the same cycle as the press pulse.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!level_q) begin
      hold_d = '0;
    end else if (tick_i && (hold_q < LONG_LAST)) begin
      hold_d = hold_q + 1'b1;
      long_d = ((hold_q + 1'b1) == LONG_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      cnt_q     <= '0;
      level_q   <= 1'b0;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel key conditioner: a shared free-running tick prescaler feeding
// N_KEYS independent debounce channels.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int N_KEYS     = 4,
  parameter int CNT_MAX    = KEY_CNT_MAX,
  parameter int TICK_DIV   = KEY_TICK_DIV,
  parameter int LONG_TICKS = KEY_LONG_TICKS,
  parameter int ACTIVE_LOW = KEY_ACTIVE_LOW
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  localparam int TDIV_W = key_width(TICK_DIV);
  localparam logic [TDIV_W-1:0] TDIV_LAST = TDIV_W'(TICK_DIV - 1);

  logic [TDIV_W-1:0] div_q, div_d;
  logic              tick;

  assign tick = (div_q == TDIV_LAST);

  always_comb begin
    div_d = div_q + 1'b1;
    if (tick) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .CNT_MAX   (CNT_MAX),
      .LONG_TICKS(LONG_TICKS),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .clk      (clk),
      .sys_rst  (sys_rst),
      .tick_i   (tick),
      .key_raw_i(key_in[g]),
      .level_o  (key_level[g]),
      .press_o  (key_press[g]),
      .release_o(key_release[g]),
      .long_o   (key_long[g])
    );
  end

endmodule
